// File: rtl/morse_pkg.sv
// ---------------------------------------------------------------------------
// morse_pkg
// Shared definitions for the Morse letter transmitter:
//   - FSM state type (IDLE, MARK, GAP, TRAIL)
//   - Morse timing constants, expressed in units
//   - letter table: code 0..25 (A..Z) -> {elem_cnt[2:0], dash_mask[3:0]}
// The dash mask is MSB-first: bit 3 is the first element, bit 2 the second,
// and so on. A set bit means that element is a dash.
// ---------------------------------------------------------------------------
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    GAP   = 2'd2,
    TRAIL = 2'd3
  } morse_state_e;

  localparam int MORSE_NUM_LETTERS = 26;
  localparam int MORSE_MAX_ELEMS   = 4;
  localparam int DOT_UNITS         = 1;
  localparam int DASH_UNITS        = 3;
  localparam int GAP_UNITS         = 1;
  localparam int TRAIL_UNITS       = 3;

  // Width of the element index; four elements fit in two bits.
  localparam int ELEM_IDX_W = $clog2(MORSE_MAX_ELEMS);

  function automatic logic [6:0] morse_letter(input logic [4:0] idx);
    logic [6:0] entry;
    entry = 7'd0;
    case (idx)
      5'd0:  entry = {3'd2, 4'b0100}; // A .-
      5'd1:  entry = {3'd4, 4'b1000}; // B -...
      5'd2:  entry = {3'd4, 4'b1010}; // C -.-.
      5'd3:  entry = {3'd3, 4'b1000}; // D -..
      5'd4:  entry = {3'd1, 4'b0000}; // E .
      5'd5:  entry = {3'd4, 4'b0010}; // F ..-.
      5'd6:  entry = {3'd3, 4'b1100}; // G --.
      5'd7:  entry = {3'd4, 4'b0000}; // H ....
      5'd8:  entry = {3'd2, 4'b0000}; // I ..
      5'd9:  entry = {3'd4, 4'b0111}; // J .---
      5'd10: entry = {3'd3, 4'b1010}; // K -.-
      5'd11: entry = {3'd4, 4'b0100}; // L .-..
      5'd12: entry = {3'd2, 4'b1100}; // M --
      5'd13: entry = {3'd2, 4'b1000}; // N -.
      5'd14: entry = {3'd3, 4'b1110}; // O ---
      5'd15: entry = {3'd4, 4'b0110}; // P .--.
      5'd16: entry = {3'd4, 4'b1101}; // Q --.-
      5'd17: entry = {3'd3, 4'b0100}; // R .-.
      5'd18: entry = {3'd3, 4'b0000}; // S ...
      5'd19: entry = {3'd1, 4'b1000}; // T -
      5'd20: entry = {3'd3, 4'b0010}; // U ..-
      5'd21: entry = {3'd4, 4'b0001}; // V ...-
      5'd22: entry = {3'd3, 4'b0110}; // W .--
      5'd23: entry = {3'd4, 4'b1001}; // X -..-
      5'd24: entry = {3'd4, 4'b1011}; // Y -.--
      5'd25: entry = {3'd4, 4'b1100}; // Z --..
      default: entry = 7'd0;
    endcase
    return entry;
  endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// ---------------------------------------------------------------------------
// morse_unit_timer
// Down-counter that produces one tick per Morse unit (CLK_DIV cycles).
// Ports:
//   clock  - system clock
//   reset  - asynchronous, active-low reset (loads CLK_DIV-1)
//   run    - count enable; the counter holds while low
//   clear  - synchronous reload to CLK_DIV-1 (letter acceptance / abort)
//   tick   - high in the last enabled cycle of each unit
// ---------------------------------------------------------------------------
module morse_unit_timer
  import morse_pkg::*;
#(
  parameter int CLK_DIV = 25000000
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam logic [27:0] RELOAD = 28'(CLK_DIV - 1);

  logic [27:0] timer_q, timer_d;

  assign tick = run && (timer_q == 28'd0);

  // Reload on every tick so the next unit starts immediately; CLK_DIV=1
  // therefore ticks on every running cycle.
  always_comb begin
    timer_d = timer_q;
    if (clear || tick) begin
      timer_d = RELOAD;
    end else if (run) begin
      timer_d = timer_q - 28'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      timer_q <= RELOAD;
    end else begin
      timer_q <= timer_d;
    end
  end

endmodule

// File: rtl/morse_tx.sv
// ---------------------------------------------------------------------------
// morse_tx
// Morse letter transmitter: accepts A..Z codes over a valid/ready handshake
// and drives one LED line (dot 1 unit, dash 3, intra-letter gap 1, trail 3).
// Ports:
//   clock, reset       - system clock, asynchronous active-low reset
//   enable             - freezes timer, unit count and state while low
//   abort              - synchronous cancel of the letter in flight
//   repeat_en          - only with MORSE_TX_REPEAT_EN: replay the letter
//   in_valid, in_code  - letter offer; transfer when in_valid && in_ready
//   in_ready           - high only in IDLE
//   led                - registered Morse output
//   busy               - high outside IDLE
//   done               - one-cycle pulse in the final cycle of the trail
//   err                - one-cycle pulse after an out-of-range code is taken
// Optional feature macro: MORSE_TX_REPEAT_EN.
// ---------------------------------------------------------------------------
module morse_tx
  import morse_pkg::*;
#(
  parameter int CLK_DIV = 25000000,
  parameter int CODE_W  = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              abort,
`ifdef MORSE_TX_REPEAT_EN
  // Called repeat_en because "repeat" is a reserved word.
  input  logic              repeat_en,
`endif
  input  logic              in_valid,
  input  logic [CODE_W-1:0] in_code,
  output logic              in_ready,
  output logic              led,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [1:0] DOT_LAST   = 2'(DOT_UNITS - 1);
  localparam logic [1:0] DASH_LAST  = 2'(DASH_UNITS - 1);
  localparam logic [1:0] GAP_LAST   = 2'(GAP_UNITS - 1);
  localparam logic [1:0] TRAIL_LAST = 2'(TRAIL_UNITS - 1);

  morse_state_e          state_q, state_d;
  logic [1:0]            unit_q, unit_d;
  logic [ELEM_IDX_W-1:0] idx_q, idx_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [3:0]            mask_q, mask_d;
  logic                  led_q, led_d;
  logic                  err_q, err_d;

  logic       tick;
  logic       accept;
  logic       code_bad;
  logic       replay;
  logic       is_dash;
  logic       last_elem;
  logic [1:0] mark_last;
  logic [6:0] entry;

  // abort wins over the handshake, so an aborted offer is never taken.
  assign accept    = in_valid && (state_q == IDLE) && !abort;
  assign code_bad  = (32'(in_code) >= 32'(MORSE_NUM_LETTERS));
  assign entry     = morse_letter(5'(in_code));
  assign is_dash   = mask_q[2'd3 - idx_q];
  assign mark_last = is_dash ? DASH_LAST : DOT_LAST;
  assign last_elem = ({1'b0, idx_q} == (cnt_q - 3'd1));

`ifdef MORSE_TX_REPEAT_EN
  assign replay = repeat_en;
`else
  assign replay = 1'b0;
`endif

  morse_unit_timer #(
    .CLK_DIV(CLK_DIV)
  ) u_timer (
    .clock (clock),
    .reset (reset),
    .run   (enable && (state_q != IDLE)),
    .clear (accept || abort),
    .tick  (tick)
  );

  // Every transition happens on a unit tick, so the unit counter simply
  // restarts at zero on each state entry. done is decoded combinationally
  // so it marks the last trail cycle itself.
  always_comb begin
    state_d = state_q;
    unit_d  = unit_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    led_d   = led_q;
    err_d   = 1'b0;
    done    = 1'b0;
    if (abort) begin
      state_d = IDLE;
      unit_d  = 2'd0;
      idx_d   = '0;
      led_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (code_bad) begin
              err_d = 1'b1;
            end else begin
              cnt_d   = entry[6:4];
              mask_d  = entry[3:0];
              state_d = MARK;
              led_d   = 1'b1;
              unit_d  = 2'd0;
              idx_d   = '0;
            end
          end
        end
        MARK: begin
          if (tick) begin
            if (unit_q == mark_last) begin
              unit_d  = 2'd0;
              led_d   = 1'b0;
              state_d = last_elem ? TRAIL : GAP;
            end else begin
              unit_d = unit_q + 2'd1;
            end
          end
        end
        GAP: begin
          if (tick) begin
            if (unit_q == GAP_LAST) begin
              unit_d  = 2'd0;
              idx_d   = idx_q + 1'b1;
              led_d   = 1'b1;
              state_d = MARK;
            end else begin
              unit_d = unit_q + 2'd1;
            end
          end
        end
        TRAIL: begin
          if (tick) begin
            if (unit_q == TRAIL_LAST) begin
              done   = 1'b1;
              unit_d = 2'd0;
              idx_d  = '0;
              if (replay) begin
                state_d = MARK;
                led_d   = 1'b1;
              end else begin
                state_d = IDLE;
                led_d   = 1'b0;
              end
            end else begin
              unit_d = unit_q + 2'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      unit_q  <= 2'd0;
      idx_q   <= '0;
      cnt_q   <= 3'd0;
      mask_q  <= 4'd0;
      led_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      unit_q  <= unit_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      led_q   <= led_d;
      err_q   <= err_d;
    end
  end

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign led      = led_q;
  assign err      = err_q;

endmodule
